// File: rtl/cmv300_pkg.sv
`default_nettype none
//==============================================================================
// Module      : cmv300_pkg
// Description : Shared types and constants for the CMV300 frame emulator.
//               Holds the FSM state encoding, test-pattern codes, default
//               frame geometry and the internal counter width.
// Revision    : 1.0 - initial release
//==============================================================================
package cmv300_pkg;

   // Frame sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_LINE  = 2'd2,
      ST_BLANK = 2'd3
   } state_t;

   // Test-pattern selection codes
   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_FRAME = 2'd3;

   // Default sensor geometry (648 x 488 active pixels)
   localparam int c_DEF_PIXELS_PER_LINE = 648;
   localparam int c_DEF_LINES_PER_FRAME = 488;

   // Width of the pixel / line / delay / blank counters
   localparam int c_CNT_W = 16;

endpackage : cmv300_pkg
`default_nettype wire

// File: rtl/cmv300_pattern_gen.sv
`default_nettype none
//==============================================================================
// Module      : cmv300_pattern_gen
// Description : Combinational test-pattern pixel function. The caller
//               registers the result.
// Ports       : pattern  in  2  pattern code (PAT_*)
//               pix_lo   in  8  low byte of the pixel counter
//               line_lo  in  8  low byte of the line counter
//               frame_lo in  8  low byte of the completed-frame counter
//               pixel    out 8  pixel value
// Revision    : 1.0 - initial release
//==============================================================================
module cmv300_pattern_gen
   import cmv300_pkg::*;
(
   input  logic [1:0] pattern,
   input  logic [7:0] pix_lo,
   input  logic [7:0] line_lo,
   input  logic [7:0] frame_lo,
   output logic [7:0] pixel
);

   always_comb begin
      pixel = 8'h00;
      case (pattern)
         PAT_HRAMP: pixel = pix_lo;
         PAT_VRAMP: pixel = line_lo;
         // 8x8 checkerboard: toggles every 8 pixels and every 8 lines
         PAT_CHECK: pixel = {8{pix_lo[3] ^ line_lo[3]}};
         // Frame-indexed ramp lets the capture side spot dropped frames
         PAT_FRAME: pixel = frame_lo + pix_lo;
         default:   pixel = 8'h00;
      endcase
   end

endmodule : cmv300_pattern_gen
`default_nettype wire

// File: rtl/cmv300_frame_emulator.sv
`default_nettype none
//==============================================================================
// Module      : cmv300_frame_emulator
// Description : Stand-in for the CMV300 8-bit parallel pixel output. A rising
//               edge on frame_req (while enabled and idle) produces one full
//               frame of test-pattern pixels on line_valid/data_valid/d_out.
// Ports       : clk         in  1       pixel clock
//               rst_n       in  1       asynchronous active-low reset
//               enable      in  1       allow new frame requests
//               pattern_sel in  2       pattern code, sampled at frame start
//               frame_req   in  1       rising edge requests a frame
//               line_valid  out 1       high during active lines
//               data_valid  out 1       high on each valid pixel
//               d_out       out DATA_W  pixel data, 0 when not valid
//               frame_busy  out 1       high from accepted request to frame end
//               frame_cnt   out 16      completed frame count (wraps)
// Revision    : 1.0 - initial release
//==============================================================================
module cmv300_frame_emulator
   import cmv300_pkg::*;
#(
   parameter int PIXELS_PER_LINE = c_DEF_PIXELS_PER_LINE,
   parameter int LINES_PER_FRAME = c_DEF_LINES_PER_FRAME,
   parameter int LINE_BLANK      = 16,
   parameter int FRAME_DELAY     = 8,
   parameter int DATA_W          = 8
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [1:0]        pattern_sel,
   input  logic              frame_req,
   output logic              line_valid,
   output logic              data_valid,
   output logic [DATA_W-1:0] d_out,
   output logic              frame_busy,
   output logic [15:0]       frame_cnt
);

   localparam logic [c_CNT_W-1:0] c_PIX_LAST   = c_CNT_W'(PIXELS_PER_LINE - 1);
   localparam logic [c_CNT_W-1:0] c_LINE_LAST  = c_CNT_W'(LINES_PER_FRAME - 1);
   localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(LINE_BLANK - 1);
   localparam logic [c_CNT_W-1:0] c_DLY_LAST   = c_CNT_W'(FRAME_DELAY - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_CNT_W-1:0]   r_pix_cnt,   w_pix_cnt_nxt;
   logic [c_CNT_W-1:0]   r_line_cnt,  w_line_cnt_nxt;
   logic [c_CNT_W-1:0]   r_dly_cnt,   w_dly_cnt_nxt;
   logic [c_CNT_W-1:0]   r_blank_cnt, w_blank_cnt_nxt;
   logic [1:0]           r_pattern,   w_pattern_nxt;
   logic                 r_req_q;
   logic [15:0]          r_frame_cnt;
   logic                 w_req_accept;
   logic                 w_frame_done;

   logic                 r_line_valid;
   logic                 r_data_valid;
   logic                 r_frame_busy;
   logic [DATA_W-1:0]    r_d_out;
   logic                 w_line_valid_nxt;
   logic                 w_frame_busy_nxt;
   logic [DATA_W-1:0]    w_d_out_nxt;
   logic [7:0]           w_pixel;

   // Only a fresh 0->1 edge seen while idle and enabled starts a frame
   assign w_req_accept = frame_req & ~r_req_q & enable & (r_state == ST_IDLE);

   //---------------------------------------------------------------------------
   // State / counter / output registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_pix_cnt    <= '0;
         r_line_cnt   <= '0;
         r_dly_cnt    <= '0;
         r_blank_cnt  <= '0;
         r_pattern    <= PAT_HRAMP;
         r_req_q      <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_line_valid <= 1'b0;
         r_data_valid <= 1'b0;
         r_frame_busy <= 1'b0;
         r_d_out      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_pix_cnt    <= w_pix_cnt_nxt;
         r_line_cnt   <= w_line_cnt_nxt;
         r_dly_cnt    <= w_dly_cnt_nxt;
         r_blank_cnt  <= w_blank_cnt_nxt;
         r_pattern    <= w_pattern_nxt;
         r_req_q      <= frame_req;
         if (w_frame_done) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         r_line_valid <= w_line_valid_nxt;
         r_data_valid <= w_line_valid_nxt;
         r_frame_busy <= w_frame_busy_nxt;
         r_d_out      <= w_d_out_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and counter logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_pix_cnt_nxt   = r_pix_cnt;
      w_line_cnt_nxt  = r_line_cnt;
      w_dly_cnt_nxt   = r_dly_cnt;
      w_blank_cnt_nxt = r_blank_cnt;
      w_pattern_nxt   = r_pattern;
      w_frame_done    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_accept) begin
               w_state_nxt   = ST_DELAY;
               w_dly_cnt_nxt = '0;
               w_pattern_nxt = pattern_sel;
            end
         end
         ST_DELAY: begin
            if (r_dly_cnt == c_DLY_LAST) begin
               w_state_nxt    = ST_LINE;
               w_pix_cnt_nxt  = '0;
               w_line_cnt_nxt = '0;
            end else begin
               w_dly_cnt_nxt = r_dly_cnt + 1'b1;
            end
         end
         ST_LINE: begin
            if (r_pix_cnt == c_PIX_LAST) begin
               w_pix_cnt_nxt = '0;
               if (r_line_cnt == c_LINE_LAST) begin
                  w_state_nxt    = ST_IDLE;
                  w_line_cnt_nxt = '0;
                  w_frame_done   = 1'b1;
               end else begin
                  w_state_nxt     = ST_BLANK;
                  w_line_cnt_nxt  = r_line_cnt + 1'b1;
                  w_blank_cnt_nxt = '0;
               end
            end else begin
               w_pix_cnt_nxt = r_pix_cnt + 1'b1;
            end
         end
         ST_BLANK: begin
            if (r_blank_cnt == c_BLANK_LAST) begin
               w_state_nxt = ST_LINE;
            end else begin
               w_blank_cnt_nxt = r_blank_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Output decode. Outputs are computed from next-state values so that the
   // registered pins line up with the cycle the state/counters describe.
   //---------------------------------------------------------------------------
   cmv300_pattern_gen u_pattern_gen (
      .pattern  (w_pattern_nxt),
      .pix_lo   (w_pix_cnt_nxt[7:0]),
      .line_lo  (w_line_cnt_nxt[7:0]),
      .frame_lo (r_frame_cnt[7:0]),
      .pixel    (w_pixel)
   );

   always_comb begin
      w_line_valid_nxt = (w_state_nxt == ST_LINE);
      w_frame_busy_nxt = (w_state_nxt != ST_IDLE);
      w_d_out_nxt      = '0;
      if (w_line_valid_nxt) begin
         w_d_out_nxt = DATA_W'(w_pixel);
      end
   end

   assign line_valid = r_line_valid;
   assign data_valid = r_data_valid;
   assign d_out      = r_d_out;
   assign frame_busy = r_frame_busy;
   assign frame_cnt  = r_frame_cnt;

endmodule : cmv300_frame_emulator
`default_nettype wire

// File: tb/tb_cmv300_frame_emulator.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module      : tb_cmv300_frame_emulator
// Description : Self-checking bench for cmv300_frame_emulator using a small
//               4x3 frame geometry. Expected pixels are queued per frame and
//               consumed by a negedge monitor; timing is checked per cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_cmv300_frame_emulator;

   localparam int c_PPL  = 4;
   localparam int c_LPF  = 3;
   localparam int c_LB   = 2;
   localparam int c_FD   = 3;
   localparam int c_FLEN = c_FD + c_LPF * c_PPL + (c_LPF - 1) * c_LB;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        enable      = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        frame_req   = 1'b0;
   logic        line_valid;
   logic        data_valid;
   logic [7:0]  d_out;
   logic        frame_busy;
   logic [15:0] frame_cnt;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;
   logic [15:0] exp_fcnt = 16'd0;

   always #5 clk = ~clk;

   cmv300_frame_emulator #(
      .PIXELS_PER_LINE (c_PPL),
      .LINES_PER_FRAME (c_LPF),
      .LINE_BLANK      (c_LB),
      .FRAME_DELAY     (c_FD),
      .DATA_W          (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .frame_req   (frame_req),
      .line_valid  (line_valid),
      .data_valid  (data_valid),
      .d_out       (d_out),
      .frame_busy  (frame_busy),
      .frame_cnt   (frame_cnt)
   );

   function automatic logic [7:0] pix_model(logic [1:0] pat, int p, int l, logic [15:0] f);
      logic [7:0] pb;
      logic [7:0] lb;
      pb = p[7:0];
      lb = l[7:0];
      case (pat)
         2'd0:    return pb;
         2'd1:    return lb;
         2'd2:    return {8{pb[3] ^ lb[3]}};
         default: return f[7:0] + pb;
      endcase
   endfunction

   // line_valid expected k cycles after the accepting edge
   function automatic bit lv_model(int k);
      int t;
      if (k < c_FD || k >= c_FLEN) return 1'b0;
      t = (k - c_FD) % (c_PPL + c_LB);
      return (t < c_PPL);
   endfunction

   // Scoreboard consumer: every valid pixel must match the queue head
   always @(negedge clk) begin
      if (rst_n) begin
         total++;
         if (data_valid !== line_valid) begin
            bad++;
            $display("FAIL dv_eq_lv t=%0t data_valid=%b line_valid=%b", $time, data_valid, line_valid);
         end
         if (data_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pixel t=%0t d_out=%02h expected no pixel", $time, d_out);
            end else begin
               mon_exp = exp_q.pop_front();
               if (d_out !== mon_exp) begin
                  bad++;
                  $display("FAIL pixel t=%0t d_out=%02h expected=%02h", $time, d_out, mon_exp);
               end
            end
         end else begin
            total++;
            if (d_out !== 8'h00) begin
               bad++;
               $display("FAIL d_out_idle t=%0t d_out=%02h expected=00", $time, d_out);
            end
         end
      end
   end

   task automatic push_frame(input logic [1:0] pat, input logic [15:0] f);
      for (int l = 0; l < c_LPF; l++)
         for (int p = 0; p < c_PPL; p++)
            exp_q.push_back(pix_model(pat, p, l, f));
   endtask

   // mode 0: plain frame; 1: extra edge in line 1 and request held high
   // from the last pixel on; 2: enable dropped during line 1
   task automatic run_frame(input logic [1:0] pat, input int mode);
      @(negedge clk);
      frame_req   = 1'b0;
      pattern_sel = pat;
      @(negedge clk);
      push_frame(pat, exp_fcnt);
      frame_req = 1'b1;
      for (int k = 0; k <= c_FLEN; k++) begin
         @(negedge clk);
         total++;
         if (line_valid !== lv_model(k)) begin
            bad++;
            $display("FAIL line_valid k=%0d got=%b want=%b", k, line_valid, lv_model(k));
         end
         total++;
         if (frame_busy !== (k < c_FLEN)) begin
            bad++;
            $display("FAIL frame_busy k=%0d got=%b want=%b", k, frame_busy, (k < c_FLEN));
         end
         total++;
         if (frame_cnt !== ((k < c_FLEN) ? exp_fcnt : exp_fcnt + 16'd1)) begin
            bad++;
            $display("FAIL frame_cnt k=%0d got=%04h want=%04h", k, frame_cnt,
                     (k < c_FLEN) ? exp_fcnt : exp_fcnt + 16'd1);
         end
         if (k == 0) frame_req = 1'b0;
         if (k == 1) pattern_sel = ~pat;
         if (mode == 1 && k == 4) frame_req = 1'b1;
         if (mode == 1 && k == 5) frame_req = 1'b0;
         if (mode == 1 && k == c_FLEN - 1) frame_req = 1'b1;
         if (mode == 2 && k == 5) enable = 1'b0;
      end
      exp_fcnt = exp_fcnt + 16'd1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL pixels_left got=%0d want=0", exp_q.size());
      end
   endtask

   task automatic check_idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         total++;
         if (frame_busy !== 1'b0 || line_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle i=%0d busy=%b lv=%b want 0/0", tag, i, frame_busy, line_valid);
         end
      end
      total++;
      if (frame_cnt !== exp_fcnt) begin
         bad++;
         $display("FAIL %s_fcnt got=%04h want=%04h", tag, frame_cnt, exp_fcnt);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      total++;
      if (line_valid !== 1'b0 || data_valid !== 1'b0 || frame_busy !== 1'b0 ||
          d_out !== 8'h00 || frame_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL %s lv=%b dv=%b busy=%b d=%02h fcnt=%04h want all 0",
                  tag, line_valid, data_valid, frame_busy, d_out, frame_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset_state");
      rst_n  = 1'b1;
      enable = 1'b1;
      exp_fcnt = 16'd0;
      check_idle(3, "post_reset");
   endtask

   task automatic test_basic();
      run_frame(2'd0, 0);
   endtask

   task automatic test_patterns();
      run_frame(2'd3, 0);
      run_frame(2'd1, 0);
      run_frame(2'd2, 0);
   endtask

   task automatic test_back_to_back();
      run_frame(2'd0, 1);
      check_idle(20, "held_req");
      run_frame(2'd1, 0);
   endtask

   task automatic test_enable();
      @(negedge clk);
      enable    = 1'b0;
      frame_req = 1'b0;
      @(negedge clk);
      frame_req = 1'b1;
      repeat (3) @(negedge clk);
      frame_req = 1'b0;
      check_idle(25, "disabled");
      enable = 1'b1;
      run_frame(2'd0, 2);
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      frame_req   = 1'b0;
      pattern_sel = 2'd0;
      @(negedge clk);
      push_frame(2'd0, exp_fcnt);
      frame_req = 1'b1;
      @(negedge clk);
      frame_req = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (line_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_line2 line_valid=%b want=1", line_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("async_reset");
      exp_q.delete();
      exp_fcnt = 16'd0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(2'd1, 0);
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      exp_fcnt = 16'hFFFF;
      @(negedge clk);
      total++;
      if (frame_cnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL preset_fcnt got=%04h want=ffff", frame_cnt);
      end
      run_frame(2'd3, 0);
      total++;
      if (frame_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL wrap_fcnt got=%04h want=0000", frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      test_wrap();
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cmv300_frame_emulator
`default_nettype wire
